// File: rtl/fifo_alu_sequencer_pkg.sv
// fifo_alu_sequencer_pkg
//   Shared definitions for the UART-ALU path: sequencer state encodings
//   (3-bit binary) and the opcode constants understood by the ALU.
package fifo_alu_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_GET_A  = 3'd0,
        ST_GET_B  = 3'd1,
        ST_GET_OP = 3'd2,
        ST_EXEC   = 3'd3,
        ST_SEND   = 3'd4
    } state_e;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

endpackage

// File: rtl/fifo_alu_sequencer_frame_timer.sv
// frame_timer
//   Inter-byte timeout counter for the sequencer.
//   clk, reset : clock, asynchronous active-high reset
//   clr        : synchronous clear (wins over en)
//   en         : count one cycle; the counter saturates at all-ones
//   expired    : counter equals TIMEOUT-1 (never asserted when TIMEOUT=0)
module frame_timer #(
    parameter int TO_W    = 16,
    parameter int TIMEOUT = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TO_W-1:0] LIM = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [TO_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en && (cnt_q != {TO_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign expired = (TIMEOUT != 0) && (cnt_q == LIM);

endmodule

// File: rtl/fifo_alu_sequencer.sv
// fifo_alu_sequencer
//   Pops A, B, opcode from the RX FIFO, lets the external combinational ALU
//   work for one cycle on the registered operands, registers the result and
//   pushes it into the TX FIFO. A frame stalled too long between bytes is
//   dropped with an err pulse.
//   clk, reset          : clock, asynchronous active-high reset
//   rx_empty/rx_data/rx_rd : RX FIFO flag, head word, pop strobe
//   tx_full/tx_wr/tx_data  : TX FIFO flag, push strobe, pushed word
//   alu_a/alu_b/alu_op  : registered ALU operands / opcode
//   alu_res             : ALU result (combinational)
//   busy                : a frame is in progress (state != GET_A)
//   done / err          : one-cycle pulses for result pushed / frame dropped
module fifo_alu_sequencer
    import fifo_alu_sequencer_pkg::*;
#(
    parameter int B       = 8,
    parameter int OP_W    = 6,
    parameter int TO_W    = 16,
    parameter int TIMEOUT = 50000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx_empty,
    input  logic [B-1:0]    rx_data,
    output logic            rx_rd,
    input  logic            tx_full,
    output logic            tx_wr,
    output logic [B-1:0]    tx_data,
    output logic [B-1:0]    alu_a,
    output logic [B-1:0]    alu_b,
    output logic [OP_W-1:0] alu_op,
    input  logic [B-1:0]    alu_res,
    output logic            busy,
    output logic            done,
    output logic            err
);

    state_e          state_q, state_d;
    logic [B-1:0]    a_q, a_d, b_q, b_d, res_q, res_d;
    logic [OP_W-1:0] op_q, op_d;
    logic            tmr_clr, tmr_en, tmr_expired;
    logic            in_wait;   // waiting for byte 2 or 3: timeout applies

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_GET_A;
        else       state_q <= state_d;
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_GET_A:  if (!rx_empty) state_d = ST_GET_B;
            ST_GET_B:  if (!rx_empty) state_d = ST_GET_OP;
                       else if (tmr_expired) state_d = ST_GET_A;
            ST_GET_OP: if (!rx_empty) state_d = ST_EXEC;
                       else if (tmr_expired) state_d = ST_GET_A;
            ST_EXEC:   state_d = ST_SEND;
            ST_SEND:   if (!tx_full) state_d = ST_GET_A;
            default:   state_d = ST_GET_A;
        endcase
    end

    // ---------------- outputs ----------------
    // Strobes are gated by reset so the FIFOs never see a pop/push while the
    // block is being reset, even though the state is already GET_A.
    always_comb begin
        in_wait = (state_q == ST_GET_B) || (state_q == ST_GET_OP);
        rx_rd   = !reset && !rx_empty &&
                  ((state_q == ST_GET_A) || in_wait);
        tx_wr   = !reset && !tx_full && (state_q == ST_SEND);
        done    = tx_wr;
        err     = !reset && in_wait && rx_empty && tmr_expired;
        busy    = (state_q != ST_GET_A);
        tmr_en  = in_wait && rx_empty;
        tmr_clr = (state_d != state_q);
    end

    // ---------------- datapath registers ----------------
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        op_d  = op_q;
        res_d = res_q;
        if (rx_rd) begin
            case (state_q)
                ST_GET_A:  a_d  = rx_data;
                ST_GET_B:  b_d  = rx_data;
                ST_GET_OP: op_d = rx_data[OP_W-1:0];  // upper bits ignored
                default:   ;
            endcase
        end
        if (state_q == ST_EXEC) res_d = alu_res;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            res_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            op_q  <= op_d;
            res_q <= res_d;
        end
    end

    assign alu_a   = a_q;
    assign alu_b   = b_q;
    assign alu_op  = op_q;
    assign tx_data = res_q;

    frame_timer #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

endmodule

// File: tb/tb_fifo_alu_sequencer.sv
module tb_fifo_alu_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_empty, rx_rd, tx_full, tx_wr, busy, done, err;
    logic [7:0] rx_data, tx_data, alu_a, alu_b, alu_res;
    logic [5:0] alu_op;

    always #5 clk = ~clk;

    fifo_alu_sequencer #(.B(8), .OP_W(6), .TO_W(16), .TIMEOUT(10)) dut (
        .clk(clk), .reset(reset),
        .rx_empty(rx_empty), .rx_data(rx_data), .rx_rd(rx_rd),
        .tx_full(tx_full), .tx_wr(tx_wr), .tx_data(tx_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res),
        .busy(busy), .done(done), .err(err)
    );

    // ALU model (environment)
    always_comb begin
        case (alu_op)
            6'b100000: alu_res = alu_a + alu_b;
            6'b100010: alu_res = alu_a - alu_b;
            6'b100100: alu_res = alu_a & alu_b;
            6'b100101: alu_res = alu_a | alu_b;
            6'b100110: alu_res = alu_a ^ alu_b;
            6'b100111: alu_res = ~(alu_a | alu_b);
            6'b000011: alu_res = $unsigned($signed(alu_a) >>> alu_b);
            6'b000010: alu_res = alu_a >> alu_b;
            default:   alu_res = 8'h00;
        endcase
    end

    // RX FIFO model
    logic [7:0] rx_mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign rx_empty = (rd_ptr == wr_ptr);
    assign rx_data  = rx_mem[rd_ptr[7:0]];

    // Event monitor
    int cyc = 0, pop_n = 0, push_n = 0, done_n = 0, err_n = 0, err_cyc = 0, viol_n = 0;
    int pop_cyc [0:127];
    int push_cyc [0:63];
    logic [7:0] push_dat [0:63];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rx_rd) begin
            pop_cyc[pop_n] <= cyc;
            pop_n  <= pop_n + 1;
            rd_ptr <= rd_ptr + 1;
        end
        if (tx_wr) begin
            push_cyc[push_n] <= cyc;
            push_dat[push_n] <= tx_data;
            push_n <= push_n + 1;
        end
        if (done) done_n <= done_n + 1;
        if (err) begin
            err_cyc <= cyc;
            err_n   <= err_n + 1;
        end
        if ((done && err) || (rx_rd && tx_wr)) viol_n <= viol_n + 1;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push_rx(input logic [7:0] v);
        rx_mem[wr_ptr[7:0]] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_push(input int target, input int budget, input string nm);
        int k = 0;
        while (push_n < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (push_n < target) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: wait for push expired, pushes %0d expected %0d", nm, push_n, target);
        end
    endtask

    typedef struct {
        string      nm;
        logic [7:0] a, b, op;
        logic [5:0] exp_op;
        logic [7:0] exp_res;
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs[0] = '{"add",   8'h05, 8'h03, 8'h20, 6'b100000, 8'h08};
        vecs[1] = '{"or",    8'h0F, 8'hF0, 8'h25, 6'b100101, 8'hFF};
        vecs[2] = '{"sub",   8'h0A, 8'h03, 8'h22, 6'b100010, 8'h07};
        vecs[3] = '{"and",   8'hF0, 8'h3C, 8'h24, 6'b100100, 8'h30};
        vecs[4] = '{"xor",   8'hFF, 8'h0F, 8'h26, 6'b100110, 8'hF0};
        vecs[5] = '{"nor",   8'h0F, 8'hF0, 8'h27, 6'b100111, 8'h00};
        vecs[6] = '{"sra",   8'h80, 8'h01, 8'h03, 6'b000011, 8'hC0};
        vecs[7] = '{"srl",   8'h80, 8'h02, 8'h02, 6'b000010, 8'h20};
        vecs[8] = '{"mask",  8'h10, 8'h20, 8'hE0, 6'b100000, 8'h30};

        reset   = 1'b1;
        tx_full = 1'b0;
        repeat (2) @(negedge clk);

        // ---- reset state ----
        chk("rst rx_rd", int'(rx_rd), 0);
        chk("rst tx_wr", int'(tx_wr), 0);
        chk("rst done",  int'(done), 0);
        chk("rst err",   int'(err), 0);
        chk("rst busy",  int'(busy), 0);
        chk("rst alu_a", int'(alu_a), 0);
        chk("rst alu_b", int'(alu_b), 0);
        chk("rst alu_op", int'(alu_op), 0);
        chk("rst tx_data", int'(tx_data), 0);
        reset = 1'b0;
        @(negedge clk);

        // ---- table-driven single frames ----
        for (int i = 0; i < 9; i++) begin
            int p0, q0;
            p0 = push_n;
            q0 = pop_n;
            push_rx(vecs[i].a);
            push_rx(vecs[i].b);
            push_rx(vecs[i].op);
            wait_push(p0 + 1, 20, vecs[i].nm);
            @(negedge clk);
            chk({vecs[i].nm, " result"}, int'(push_dat[p0]), int'(vecs[i].exp_res));
            chk({vecs[i].nm, " alu_op"}, int'(alu_op), int'(vecs[i].exp_op));
            chk({vecs[i].nm, " pops"}, pop_n - q0, 3);
            chk({vecs[i].nm, " pushes"}, push_n - p0, 1);
            chk({vecs[i].nm, " busy"}, int'(busy), 0);
        end

        // ---- back-to-back frames: 10 cycles, no idle gap ----
        begin
            int p0, q0;
            p0 = push_n;
            q0 = pop_n;
            push_rx(8'h0F); push_rx(8'hF0); push_rx(8'h25);
            push_rx(8'h0A); push_rx(8'h03); push_rx(8'h22);
            wait_push(p0 + 2, 30, "b2b");
            @(negedge clk);
            chk("b2b res1", int'(push_dat[p0]), 8'hFF);
            chk("b2b res2", int'(push_dat[p0 + 1]), 8'h07);
            chk("b2b frame1 push cycle", push_cyc[p0] - pop_cyc[q0], 4);
            chk("b2b frame2 A pop cycle", pop_cyc[q0 + 3] - pop_cyc[q0], 5);
            chk("b2b total cycles", push_cyc[p0 + 1] - pop_cyc[q0] + 1, 10);
        end

        // ---- TX backpressure ----
        begin
            int p0, rel;
            p0 = push_n;
            tx_full = 1'b1;
            push_rx(8'h11); push_rx(8'h22); push_rx(8'h20);
            repeat (25) @(negedge clk);
            chk("bp no push", push_n - p0, 0);
            chk("bp tx_wr low", int'(tx_wr), 0);
            chk("bp tx_data held", int'(tx_data), 8'h33);
            chk("bp busy", int'(busy), 1);
            tx_full = 1'b0;
            rel = cyc;
            repeat (3) @(negedge clk);
            chk("bp one push", push_n - p0, 1);
            chk("bp push data", int'(push_dat[p0]), 8'h33);
            chk("bp push cycle", push_cyc[p0], rel);
        end

        // ---- inter-byte timeout ----
        begin
            int q0, e0, p0, k;
            q0 = pop_n;
            e0 = err_n;
            p0 = push_n;
            push_rx(8'h05);
            k = 0;
            while (err_n == e0 && k < 30) begin
                @(negedge clk);
                k++;
            end
            chk("to err pulses", err_n - e0, 1);
            chk("to err latency", err_cyc - pop_cyc[q0], 10);
            chk("to busy", int'(busy), 0);
            chk("to no push", push_n - p0, 0);
            chk("to alu_b stale", int'(alu_b), 8'h22);
            push_rx(8'h01); push_rx(8'h02); push_rx(8'h20);
            wait_push(p0 + 1, 20, "to next");
            @(negedge clk);
            chk("to next result", int'(push_dat[p0]), 8'h03);
            chk("to single err", err_n - e0, 1);
        end

        // ---- reset mid-frame ----
        begin
            int q0, p0, k;
            q0 = pop_n;
            p0 = push_n;
            push_rx(8'h44); push_rx(8'h55);
            k = 0;
            while (pop_n < q0 + 2 && k < 10) begin
                @(negedge clk);
                k++;
            end
            chk("mr pops before reset", pop_n - q0, 2);
            reset = 1'b1;
            push_rx(8'h09);
            #1;
            chk("mr rx_rd forced", int'(rx_rd), 0);
            chk("mr busy", int'(busy), 0);
            chk("mr alu_a", int'(alu_a), 0);
            chk("mr alu_b", int'(alu_b), 0);
            chk("mr tx_data", int'(tx_data), 0);
            repeat (2) @(negedge clk);
            chk("mr no pop in reset", pop_n - q0, 2);
            reset = 1'b0;
            push_rx(8'h01); push_rx(8'h22);
            wait_push(p0 + 1, 20, "mr next");
            @(negedge clk);
            chk("mr pushes", push_n - p0, 1);
            chk("mr next result", int'(push_dat[p0]), 8'h08);
        end

        repeat (3) @(negedge clk);
        chk("done count", done_n, push_n);
        chk("exclusivity", viol_n, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
